vector_dot_accumulator: RTL and testbench

- Computes the unsigned dot product of two VEC_LEN-element vectors that arrive one element pair per cycle over a valid/ready handshake.
- Produces one ACC_W-bit result per vector.
- Sits directly upstream of the 32-bit zero-extension stage: `out_data` drives that stage's 18-bit `input_data`, and `out_valid` qualifies the capture.
- Uses a registered multiply stage, an accumulate stage and a hold-until-accepted output register.

---
 rtl/vector_dot_accumulator.sv | 123 ++++++++++++
 tb/tb_vector_dot_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_dot_accumulator.sv
// rtl/vector_dot_accumulator.sv - streaming unsigned dot product of VEC_LEN-element vectors
// Registered multiply, accumulate, then a result register held until the consumer takes it.
module vector_dot_accumulator #(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                ready_c;
  logic                accept;
  logic [CNT_W-1:0]    cnt_q;
  logic [PROD_W-1:0]   prod_q;
  logic                prod_v;
  logic [ACC_W-1:0]    acc_q;
  logic [PROD_W-1:0]   prod_next;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_sum;

  // Operands widened before the multiply so the full product is kept.
  assign prod_next = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
  assign prod_ext  = {{(ACC_W - PROD_W){1'b0}}, prod_q};
  assign acc_sum   = acc_q + prod_ext;

  // Gated by rst_n so the upstream never sees ready while reset is held.
  assign in_ready = ready_c && rst_n;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      ACCUM: begin
        ready_c = 1'b1;
        if (in_valid && (cnt_q == CNT_LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          // The previous product folds in while the new one is captured.
          if (prod_v) begin
            acc_q <= acc_sum;
          end
          if (accept) begin
            prod_q <= prod_next;
            prod_v <= 1'b1;
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          end else begin
            prod_v <= 1'b0;
          end
        end
        DRAIN: begin
          out_data  <= acc_sum;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_q     <= '0;
            prod_v    <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dot_accumulator.sv
// tb/tb_vector_dot_accumulator.sv - self-checking bench for vector_dot_accumulator
module tb_vector_dot_accumulator;

  localparam int DATA_W  = 8;
  localparam int VEC_LEN = 4;
  localparam int ACC_W   = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] a_in = '0;
  logic [DATA_W-1:0] b_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [ACC_W-1:0] exp_q[$];
  int               out_times[$];

  typedef struct {
    logic [VEC_LEN-1:0][DATA_W-1:0] a;
    logic [VEC_LEN-1:0][DATA_W-1:0] b;
    int                             gap;
    logic [ACC_W-1:0]               exp;
  } vec_t;

  vector_dot_accumulator #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT, got none expected event", name);
  endtask

  // Scoreboard: one pop per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        check("result", out_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [ACC_W-1:0] dot(input vec_t v);
    logic [ACC_W-1:0] s = '0;
    for (int i = 0; i < VEC_LEN; i++) s += ACC_W'(v.a[i]) * ACC_W'(v.b[i]);
    return s;
  endfunction

  task automatic send_elem(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic rdy;
    int n = 0;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) timeout_fail("in_ready");
  endtask

  task automatic send_vector(input vec_t v, input bit hold);
    for (int i = 0; i < VEC_LEN; i++) begin
      if (i == VEC_LEN - 1) exp_q.push_back(v.exp);
      send_elem(v.a[i], v.b[i]);
      if (v.gap > 0 && i < VEC_LEN - 1) begin
        in_valid = 1'b0;
        repeat (v.gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) timeout_fail("out_valid");
  endtask

  vec_t tbl[5];
  vec_t v, v2;

  initial begin
    tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, gap: 0, exp: 18'd70};
    tbl[1] = '{a: {4{8'd255}}, b: {4{8'd255}}, gap: 0, exp: 18'd260100};
    tbl[2] = '{a: {8'd1, 8'd7, 8'd0, 8'd10}, b: {8'd100, 8'd3, 8'd9, 8'd10}, gap: 3, exp: 18'd221};
    tbl[3] = '{a: {4{8'd0}}, b: {4{8'd200}}, gap: 1, exp: 18'd0};
    tbl[4] = '{a: {8'd255, 8'd0, 8'd0, 8'd1}, b: {8'd255, 8'd0, 8'd0, 8'd1}, gap: 2, exp: 18'd65026};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven vectors with out_ready held high
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 5; t++) begin
      send_vector(tbl[t], 0);
      wait_drain();
    end

    // Latency and handshake timing around one result
    for (int i = 0; i < VEC_LEN; i++) begin
      if (i == VEC_LEN - 1) exp_q.push_back(18'd70);
      send_elem(DATA_W'(i + 1), DATA_W'(i + 5));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    @(negedge clk);
    check("hold_out_valid", out_valid, 1);
    check("hold_in_ready", in_ready, 0);
    @(negedge clk);
    check("after_out_valid", out_valid, 0);
    check("after_in_ready", in_ready, 1);
    wait_drain();

    // Output backpressure with the next vector waiting on the input
    out_ready = 1'b0;
    v  = '{a: {4{8'd2}}, b: {4{8'd3}}, gap: 0, exp: 18'd24};
    v2 = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd1, 8'd2, 8'd3, 8'd4}, gap: 0, exp: 18'd20};
    fork
      begin
        send_vector(v, 1);
        send_vector(v2, 0);
      end
      begin
        wait_out_valid();
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("bp_out_data", out_data, 24);
          check("bp_out_valid", out_valid, 1);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset after two elements discards the partial vector
    send_elem(8'd9, 8'd9);
    send_elem(8'd9, 8'd9);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = '{a: {4{8'd1}}, b: {4{8'd1}}, gap: 0, exp: 18'd4};
    send_vector(v, 0);
    wait_drain();

    // Reset while a result is held
    out_ready = 1'b0;
    v = '{a: {4{8'd5}}, b: {4{8'd6}}, gap: 0, exp: 18'd120};
    send_vector(v, 0);
    wait_out_valid();
    check("hold_data_before_rst", out_data, 120);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("hold_rst_out_valid", out_valid, 0);
    check("hold_rst_out_data", out_data, 0);
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Three back-to-back random vectors
    out_times.delete();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        v.a[i] = DATA_W'($urandom_range(255));
        v.b[i] = DATA_W'($urandom_range(255));
      end
      v.gap = 0;
      v.exp = dot(v);
      send_vector(v, t < 2);
    end
    wait_drain();
    check("b2b_count", out_times.size(), 3);
    if (out_times.size() == 3) begin
      check("b2b_period0", out_times[1] - out_times[0], VEC_LEN + 2);
      check("b2b_period1", out_times[2] - out_times[1], VEC_LEN + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
